// File: rtl/neuron_mac_lanes.sv
// LANES-wide signed MAC neuron: weight RAM, runtime bias, saturating accumulate and ReLU.
// Define NEURON_OVF_FLAG_EN to add the sticky ovf_flag output.
module neuron_mac_lanes #(
  parameter int LAYER_NO         = 1,
  parameter int NEURON_NO        = 0,
  parameter int NUM_WEIGHT       = 30,
  parameter int LANES            = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          weight_valid,
  input  logic                          bias_valid,
  input  logic [31:0]                   weight_value,
  input  logic [31:0]                   bias_value,
  input  logic [31:0]                   config_layer_num,
  input  logic [31:0]                   config_neuron_num,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef NEURON_OVF_FLAG_EN
  ,
  output logic                          ovf_flag
`endif
);

  localparam int DW         = DATA_WIDTH;
  localparam int ACC_W      = 2 * DW;
  localparam int BEATS      = (NUM_WEIGHT + LANES - 1) / LANES;
  localparam int LSW        = ACC_W + $clog2(LANES);
  localparam int ASW        = LSW + 1;
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW         = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int LAST_LANES = NUM_WEIGHT - (BEATS - 1) * LANES;
  localparam int SLICE_HI   = ACC_W - 1 - WEIGHT_INT_WIDTH;

  localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic        [DW-1:0]    CLAMP_VAL = (WEIGHT_INT_WIDTH == 1) ? {1'b0, {(DW-1){1'b1}}} : {DW{1'b1}};

  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, BIAS, ACT, HOLD} state_t;

  function automatic logic acc_ovf(input logic signed [ASW-1:0] v);
    acc_ovf = (v > ASW'(ACC_MAX)) || (v < ASW'(ACC_MIN));
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_sat(input logic signed [ASW-1:0] v);
    if (v > ASW'(ACC_MAX))      acc_sat = ACC_MAX;
    else if (v < ASW'(ACC_MIN)) acc_sat = ACC_MIN;
    else                        acc_sat = v[ACC_W-1:0];
  endfunction

  // A pinned accumulator means the true sum overflowed, so it narrows to full scale too.
  function automatic logic relu_clamp(input logic signed [ACC_W-1:0] a);
    relu_clamp = !a[ACC_W-1] && ((a == ACC_MAX) || (a[ACC_W-1:SLICE_HI+1] != '0));
  endfunction

  function automatic logic [DW-1:0] relu(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1])        relu = '0;
    else if (relu_clamp(a)) relu = CLAMP_VAL;
    else                   relu = a[SLICE_HI -: DW];
  endfunction

  state_t                   state_r, state_n;
  logic                     in_ready_r, out_valid_r;
  logic [DW-1:0]            out_data_r;
  logic [BW-1:0]            beat_cnt_r;
  logic [1:0]               flush_cnt_r;
  logic signed [DW-1:0]     bias_r;
  logic [PW-1:0]            ptr_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     v_rd_r, v_op_r, v_prod_r, v_sum_r;
  logic signed [LSW-1:0]    lsum_r, lsum_s;
  logic signed [ACC_W-1:0]  prod_s [LANES];
  logic signed [ACC_W-1:0]  bias_sh_s;
  logic signed [ASW-1:0]    acc_add_s, acc_bias_s;
  logic                     accept_s, last_beat_s, cfg_match_s, wr_en_s, bias_en_s, handshake_s;
  logic [BW-1:0]            wr_row_s;
  logic [LW-1:0]            wr_lane_s;
  logic                     unused_bits_s;

  assign accept_s      = in_valid && in_ready_r;
  assign last_beat_s   = (beat_cnt_r == BW'(BEATS - 1));
  assign cfg_match_s   = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign wr_en_s       = weight_valid && cfg_match_s && (state_r == IDLE);
  assign bias_en_s     = bias_valid && cfg_match_s && (state_r == IDLE);
  assign handshake_s   = (state_r == HOLD) && out_ready;
  assign wr_row_s      = BW'(int'(ptr_r) / LANES);
  assign wr_lane_s     = LW'(int'(ptr_r) % LANES);
  assign bias_sh_s     = {bias_r, DW'(0)};
  assign acc_add_s     = ASW'(acc_r) + ASW'(lsum_r);
  assign acc_bias_s    = ASW'(acc_r) + ASW'(bias_sh_s);
  assign unused_bits_s = ^{weight_value[31:DW], bias_value[31:DW]};

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam bit PAD = (g >= LAST_LANES);
    logic signed [DW-1:0]    mem [BEATS];
    logic signed [DW-1:0]    w_rd_r, x_rd_r, w_op_r, x_op_r;
    logic signed [ACC_W-1:0] prod_r;

    // Weight RAM write port; contents survive reset
    always_ff @(posedge clk) begin
      if (wr_en_s && (wr_lane_s == LW'(g))) mem[wr_row_s] <= weight_value[DW-1:0];
    end

    // RAM read, operand and product stages; padded lanes of the last beat read as zero
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_rd_r <= '0;
        x_rd_r <= '0;
        w_op_r <= '0;
        x_op_r <= '0;
        prod_r <= '0;
      end else begin
        if (accept_s) begin
          if (PAD && last_beat_s) begin
            w_rd_r <= '0;
            x_rd_r <= '0;
          end else begin
            w_rd_r <= mem[beat_cnt_r];
            x_rd_r <= in_data[g*DW +: DW];
          end
        end
        w_op_r <= w_rd_r;
        x_op_r <= x_rd_r;
        prod_r <= ACC_W'(w_op_r) * ACC_W'(x_op_r);
      end
    end

    assign prod_s[g] = prod_r;
  end

  // Exact lane sum
  always_comb begin
    lsum_s = '0;
    for (int i = 0; i < LANES; i++) lsum_s = lsum_s + LSW'(prod_s[i]);
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_n = last_beat_s ? FLUSH : ACCUM; else state_n = IDLE;
      ACCUM:   if (accept_s && last_beat_s) state_n = FLUSH; else state_n = ACCUM;
      FLUSH:   if (flush_cnt_r == 2'd3) state_n = BIAS; else state_n = FLUSH;
      BIAS:    state_n = ACT;
      ACT:     state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE; else state_n = HOLD;
      default: state_n = IDLE;
    endcase
  end

  // Control, config, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      acc_r       <= '0;
      beat_cnt_r  <= '0;
      flush_cnt_r <= 2'd0;
      bias_r      <= '0;
      ptr_r       <= '0;
      v_rd_r      <= 1'b0;
      v_op_r      <= 1'b0;
      v_prod_r    <= 1'b0;
      v_sum_r     <= 1'b0;
      lsum_r      <= '0;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == IDLE) || (state_n == ACCUM);
      v_rd_r     <= accept_s;
      v_op_r     <= v_rd_r;
      v_prod_r   <= v_op_r;
      v_sum_r    <= v_prod_r;
      lsum_r     <= lsum_s;
      if (wr_en_s) ptr_r <= (ptr_r == PW'(NUM_WEIGHT - 1)) ? '0 : ptr_r + PW'(1);
      if (bias_en_s) bias_r <= bias_value[DW-1:0];
      if (handshake_s) beat_cnt_r <= '0;
      else if (accept_s) beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BW'(1);
      flush_cnt_r <= (state_r == FLUSH) ? flush_cnt_r + 2'd1 : 2'd0;
      if (handshake_s)          acc_r <= '0;
      else if (state_r == BIAS) acc_r <= acc_sat(acc_bias_s);
      else if (v_sum_r)         acc_r <= acc_sat(acc_add_s);
      if (state_r == ACT) begin
        out_data_r  <= relu(acc_r);
        out_valid_r <= 1'b1;
      end else if (handshake_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef NEURON_OVF_FLAG_EN
  logic ovf_r, ovf_evt_s, drop_s;

  assign drop_s = cfg_match_s && (weight_valid || bias_valid) && (state_r != IDLE);

  // Overflow event sources
  always_comb begin
    ovf_evt_s = (v_sum_r && acc_ovf(acc_add_s))
             || ((state_r == BIAS) && acc_ovf(acc_bias_s))
             || ((state_r == ACT) && relu_clamp(acc_r))
             || drop_s;
  end

  // Sticky flag, restarted by the first beat of the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           ovf_r <= 1'b0;
    else if (accept_s && state_r == IDLE) ovf_r <= ovf_evt_s;
    else                                  ovf_r <= ovf_r | ovf_evt_s;
  end

  assign ovf_flag = ovf_r;
`endif

endmodule
